// File: rtl/priority_request_drain_pkg.sv
// prio_pkg: shared sizes, drain FSM state encoding and the one-hot index helper.
package prio_pkg;
   localparam int N = 128;
   localparam int W = $clog2(N);
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;
   function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
      onehot = '0;
      onehot[idx] = 1'b1;
   endfunction
endpackage

// File: rtl/priority_request_drain_if.sv
// priority_request_drain_if: request-vector input stream and index output stream.
interface priority_request_drain_if;
   import prio_pkg::*;
   logic         req_valid;
   logic         req_ready;
   logic [N-1:0] req_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_last;
   modport master (output req_valid, req_vec, out_ready, input req_ready, out_valid, out_idx, out_last);
   modport slave (input req_valid, req_vec, out_ready, output req_ready, out_valid, out_idx, out_last);
endinterface

// File: rtl/priority_request_drain_encoder.sv
// priority_encoder_128: combinational index of the highest set bit plus an any-set flag.
module priority_encoder_128
   import prio_pkg::*;
(
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         any_valid
);
   // ascending scan so the highest set bit is the last to write idx
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++)
         if (req[i]) idx = W'(i);
   end
   assign any_valid = |req;
endmodule

// File: rtl/priority_request_drain.sv
// priority_request_drain: loads a request vector and drains its set bits highest-index first, one per cycle.
module priority_request_drain
   import prio_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   priority_request_drain_if.slave   bus,
   output logic [W:0]                grant_cnt,
   output logic                      busy
);
   localparam logic [0:0] S_IDLE  = IDLE;
   localparam logic [0:0] S_DRAIN = DRAIN;
   logic [0:0]   state;
   logic [N-1:0] pending;
   logic [N-1:0] rest;
   logic [W-1:0] idx;
   logic         any_valid;
   priority_encoder_128 u_enc (.req(pending), .idx(idx), .any_valid(any_valid));
   assign busy          = (state == S_DRAIN);
   assign rest          = pending & ~onehot(idx);
   assign bus.req_ready = ~busy & ~flush;
   assign bus.out_valid = busy;
   assign bus.out_idx   = idx;
   assign bus.out_last  = busy & (rest == '0);
   // flush wins over both handshakes; pending is always zero while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pending   <= '0;
         grant_cnt <= '0;
      end else if (flush) begin
         state   <= S_IDLE;
         pending <= '0;
      end else if (!busy) begin
         if (bus.req_valid) begin
            grant_cnt <= '0;
            if (bus.req_vec != '0) begin
               pending <= bus.req_vec;
               state   <= S_DRAIN;
            end
         end
      end else if (bus.out_ready) begin
         pending   <= rest;
         grant_cnt <= grant_cnt + 1'b1;
         if (bus.out_last) state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_priority_request_drain.sv
// tb_priority_request_drain: directed plus random stimulus against a queue-based drain model.
module tb_priority_request_drain;
   import prio_pkg::*;
   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [W:0]   grant_cnt;
   logic         busy;
   int           n_chk = 0;
   int           n_pass = 0;
   int           mq[$];
   int           mcnt = 0;
   priority_request_drain_if bus ();
   priority_request_drain dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .grant_cnt(grant_cnt), .busy(busy));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [N-1:0] rand_vec(input int sel);
      logic [N-1:0] v;
      v = '0;
      case (sel)
         0: v = '0;
         1, 2: v = {$urandom, $urandom, $urandom, $urandom};
         7: v = '1;
         default: for (int k = 0; k < 3; k++) v[$urandom_range(N-1)] = 1'b1;
      endcase
      return v;
   endfunction
   // one clock: drive inputs, check outputs mid-cycle against the model, then advance the model
   task automatic cycle(input logic r, input logic f, input logic rv, input logic [N-1:0] v, input logic ordy);
      rst = r;
      flush = f;
      bus.req_valid = rv;
      bus.req_vec = v;
      bus.out_ready = ordy;
      @(negedge clk);
      chk("req_ready", bus.req_ready, mq.size() == 0 && !f);
      chk("out_valid", bus.out_valid, mq.size() != 0);
      chk("busy", busy, mq.size() != 0);
      chk("out_idx", bus.out_idx, mq.size() != 0 ? mq[0] : 0);
      chk("out_last", bus.out_last, mq.size() == 1);
      chk("grant_cnt", grant_cnt, mcnt);
      if (mq.size() != 0) chk("enc_valid", dut.any_valid, 1'b1);
      if (r) begin
         mq.delete();
         mcnt = 0;
      end else if (f) mq.delete();
      else if (mq.size() == 0) begin
         if (rv) begin
            mcnt = 0;
            for (int i = N - 1; i >= 0; i--) if (v[i]) mq.push_back(i);
         end
      end else if (ordy) begin
         void'(mq.pop_front());
         mcnt++;
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [N-1:0] v;
      rst = 1'b1;
      flush = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_vec = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      cycle(1, 0, 0, '0, 0);
      cycle(1, 0, 0, '0, 0);
      v = '0;
      v[127] = 1'b1; v[64] = 1'b1; v[3] = 1'b1; v[0] = 1'b1;
      cycle(0, 0, 1, v, 1);
      repeat (5) cycle(0, 0, 0, '0, 1);
      chk("t2_grant", grant_cnt, 4);
      v = '0;
      v[5] = 1'b1; v[2] = 1'b1;
      cycle(0, 0, 1, v, 0);
      repeat (3) cycle(0, 0, 0, '0, 0);
      repeat (3) cycle(0, 0, 0, '0, 1);
      chk("t3_grant", grant_cnt, 2);
      cycle(0, 0, 1, '0, 1);
      repeat (2) cycle(0, 0, 0, '0, 1);
      chk("t4_grant", grant_cnt, 0);
      cycle(0, 0, 1, '1, 1);
      repeat (129) cycle(0, 0, 0, '0, 1);
      chk("t5_grant", grant_cnt, 128);
      cycle(0, 0, 1, '1, 1);
      repeat (10) cycle(0, 0, 0, '0, 1);
      cycle(0, 1, 1, '1, 1);
      cycle(0, 0, 0, '0, 1);
      chk("t5_flush_grant", grant_cnt, 10);
      v = '0;
      v[100] = 1'b1; v[50] = 1'b1;
      cycle(0, 0, 1, v, 1);
      cycle(0, 0, 0, '0, 1);
      cycle(1, 0, 0, '0, 1);
      repeat (2) cycle(0, 0, 0, '0, 1);
      chk("t6_grant", grant_cnt, 0);
      for (int k = 0; k < 800; k++)
         cycle($urandom_range(99) == 0, $urandom_range(29) == 0, 1'($urandom_range(1)),
               rand_vec($urandom_range(7)), $urandom_range(3) != 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
